// File: rtl/dense_layer_seq.sv
// Sequential fixed-point fully-connected layer: y = act(W*x + b), one MAC per cycle.
// Rows are evaluated in order; each row takes N_IN MAC cycles followed by one FIN cycle.
module dense_layer_seq #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             relu_en,
    input  logic [N_IN*DATA_W-1:0]           x,
    input  logic [N_IN*N_OUT*DATA_W-1:0]     w,
    input  logic [N_OUT*DATA_W-1:0]          b,
    output logic [N_OUT*DATA_W-1:0]          y,
    output logic                             busy,
    output logic                             done
);

    localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW    = (N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1;

    localparam logic signed [ACC_W:0] SMAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SMIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 i_q;
    logic [JW-1:0]                 j_q;
    logic [KW-1:0]                 k_q;
    logic signed [ACC_W-1:0]       acc_q;

    logic [N_IN*DATA_W-1:0]        x_q;
    logic [N_IN*N_OUT*DATA_W-1:0]  w_q;
    logic [N_OUT*DATA_W-1:0]       b_q;
    logic                          relu_q;

    logic signed [DATA_W-1:0]      x_el, w_el, b_el, res;
    logic signed [2*DATA_W-1:0]    prod;
    logic signed [ACC_W-1:0]       acc_sh;
    logic signed [ACC_W:0]         sum;
    logic                          last_i, last_j;

    function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W:0] v);
        if (v > SMAX) return SMAX[DATA_W-1:0];
        if (v < SMIN) return SMIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] v,
                                                        input logic en);
        return (en && v[DATA_W-1]) ? '0 : v;
    endfunction

    // Weights are stored row-major, so a single running index k walks them in MAC order.
    assign x_el   = x_q[int'(i_q)*DATA_W +: DATA_W];
    assign w_el   = w_q[int'(k_q)*DATA_W +: DATA_W];
    assign b_el   = b_q[int'(j_q)*DATA_W +: DATA_W];
    assign prod   = $signed({{DATA_W{x_el[DATA_W-1]}}, x_el}) * $signed({{DATA_W{w_el[DATA_W-1]}}, w_el});
    assign acc_sh = acc_q >>> FRAC;
    assign sum    = $signed({acc_sh[ACC_W-1], acc_sh})
                  + $signed({{(ACC_W+1-DATA_W){b_el[DATA_W-1]}}, b_el});
    assign res    = relu_fn(sat_fn(sum), relu_q);
    assign last_i = (i_q == IW'(N_IN-1));
    assign last_j = (j_q == JW'(N_OUT-1));
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (last_i) state_d = FIN;
            FIN:     state_d = last_j ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture at the accept edge; the loader may change its buses afterwards.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            x_q    <= x;
            w_q    <= w;
            b_q    <= b;
            relu_q <= relu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
                    k_q   <= k_q + 1'b1;
                    if (!last_i) i_q <= i_q + 1'b1;
                end
                FIN: begin
                    y[int'(j_q)*DATA_W +: DATA_W] <= res;
                    if (last_j) begin
                        done <= 1'b1;
                    end else begin
                        j_q   <= j_q + 1'b1;
                        i_q   <= '0;
                        acc_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: table vectors, random runs against an arithmetic model,
// and hand-written sequences for busy-start, mid-run reset, back-to-back and a 4x3 instance.
module tb_dense_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, relu_en, busy, done;
    logic [31:0]  x, b, y;
    logic [63:0]  w;

    logic         start2, relu2, busy2, done2;
    logic [63:0]  x2;
    logic [191:0] w2;
    logic [47:0]  b2, y2;

    int checks = 0;
    int errors = 0;

    dense_layer_seq #(.N_IN(2), .N_OUT(2), .DATA_W(16), .FRAC(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .x(x), .w(w), .b(b), .y(y), .busy(busy), .done(done)
    );

    dense_layer_seq #(.N_IN(4), .N_OUT(3), .DATA_W(16), .FRAC(8)) dut_b (
        .clk(clk), .rst(rst), .start(start2), .relu_en(relu2),
        .x(x2), .w(w2), .b(b2), .y(y2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [15:0] x0, x1, w00, w01, w10, w11, b0, b1;
        logic        r;
        logic [15:0] e0, e1;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: dot product in wide integers, floor shift, add bias, clamp, optional ReLU.
    function automatic logic [15:0] ref_out(input int n, input logic [15:0] xs [4],
                                            input logic [15:0] ws [4], input logic [15:0] bj,
                                            input logic r);
        longint acc, s;
        acc = 0;
        for (int i = 0; i < n; i++)
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        s = (acc >>> 8) + longint'($signed(bj));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (r && s < 0) s = 0;
        return s[15:0];
    endfunction

    function automatic logic [15:0] rv();
        logic [15:0] t;
        if ($urandom_range(1) == 1) return 16'($urandom);
        t = 16'($urandom_range(1023));
        return t - 16'd512;
    endfunction

    task automatic run_a(input logic [31:0] xv, input logic [63:0] wv, input logic [31:0] bv,
                         input logic r, input string tag);
        int k, bc;
        x = xv; w = wv; b = bv; relu_en = r; start = 1'b1;
        tick();
        start = 1'b0;
        x = $urandom; w = {$urandom, $urandom}; b = $urandom; relu_en = 1'($urandom);
        k = 0; bc = 0;
        while (k < 40) begin
            if (done) break;
            if (busy) bc++;
            tick();
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd6);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'd6);
        chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_b(input logic [63:0] xv, input logic [191:0] wv, input logic [47:0] bv,
                         input logic r, input string tag);
        int k, bc;
        x2 = xv; w2 = wv; b2 = bv; relu2 = r; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        x2 = {$urandom, $urandom}; w2 = '0; b2 = 48'($urandom);
        k = 0; bc = 0;
        while (k < 60) begin
            if (done2) break;
            if (busy2) bc++;
            tick();
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd15);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'd15);
    endtask

    logic [15:0] xs [4];
    logic [15:0] ws [4];

    initial begin : main
        logic [31:0]  xv, bv;
        logic [63:0]  wv, xv2;
        logic [191:0] wv2;
        logic [47:0]  bv2;
        logic         r;
        int           nd, first, second;

        tbl[0] = '{16'h0100, 16'h0200, 16'h0080, 16'h0040, 16'hFF00, 16'h0080, 16'h0080, 16'hFFC0, 1'b0, 16'h0180, 16'hFFC0};
        tbl[1] = '{16'h0100, 16'h0200, 16'h0080, 16'h0040, 16'hFF00, 16'h0080, 16'h0080, 16'hFFC0, 1'b1, 16'h0180, 16'h0000};
        tbl[2] = '{16'h6400, 16'h6400, 16'h0200, 16'h0200, 16'hFE00, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h8000};
        tbl[3] = '{16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
        tbl[5] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};

        rst = 1'b1; start = 1'b0; relu_en = 1'b0; x = '0; w = '0; b = '0;
        start2 = 1'b0; relu2 = 1'b0; x2 = '0; w2 = '0; b2 = '0;
        tick();
        tick();
        chk("reset_y", {32'd0, y}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_y2", {16'd0, y2}, 64'd0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            run_a({tbl[t].x1, tbl[t].x0}, {tbl[t].w11, tbl[t].w10, tbl[t].w01, tbl[t].w00},
                  {tbl[t].b1, tbl[t].b0}, tbl[t].r, $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_y0", t), {48'd0, y[15:0]}, {48'd0, tbl[t].e0});
            chk($sformatf("tbl%0d_y1", t), {48'd0, y[31:16]}, {48'd0, tbl[t].e1});
            tick();
            chk($sformatf("tbl%0d_done_pulse", t), {63'd0, done}, 64'd0);
        end

        for (int n = 0; n < 25; n++) begin
            xv = {rv(), rv()};
            wv = {rv(), rv(), rv(), rv()};
            bv = {rv(), rv()};
            r  = 1'($urandom);
            run_a(xv, wv, bv, r, $sformatf("rnd%0d", n));
            xs[0] = xv[15:0]; xs[1] = xv[31:16]; xs[2] = '0; xs[3] = '0;
            for (int j = 0; j < 2; j++) begin
                ws[0] = wv[(j*2)*16 +: 16]; ws[1] = wv[(j*2+1)*16 +: 16]; ws[2] = '0; ws[3] = '0;
                chk($sformatf("rnd%0d_y%0d", n, j), {48'd0, y[j*16 +: 16]},
                    {48'd0, ref_out(2, xs, ws, bv[j*16 +: 16], r)});
            end
        end

        // A second start mid-run carrying different operands must be ignored.
        x = 32'h0200_0100; w = 64'h0080_FF00_0040_0080; b = 32'hFFC0_0080; relu_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        x = 32'h6400_6400; w = 64'hFE00_FE00_0200_0200; b = '0;
        nd = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                nd++;
                if (first < 0) first = k;
            end
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        chk("busy_start_done_count", 64'(nd), 64'd1);
        chk("busy_start_done_time", 64'(first), 64'd6);
        chk("busy_start_y", {32'd0, y}, 64'hFFC0_0180);

        // Reset in the middle of a run.
        x = 32'h0200_0100; w = 64'h0080_FF00_0040_0080; b = 32'hFFC0_0080; relu_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        chk("midreset_y", {32'd0, y}, 64'd0);
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) nd++;
            tick();
        end
        chk("midreset_no_done", 64'(nd), 64'd0);
        run_a(32'h0200_0100, 64'h0080_FF00_0040_0080, 32'hFFC0_0080, 1'b0, "after_reset");
        chk("after_reset_y", {32'd0, y}, 64'hFFC0_0180);
        tick();

        // Start held high: runs repeat every L+1 = 7 cycles.
        x = 32'h0200_0100; w = 64'h0080_FF00_0040_0080; b = 32'hFFC0_0080; relu_en = 1'b1;
        start = 1'b1;
        tick();
        nd = 0; first = -1; second = -1;
        for (int k = 0; k < 22; k++) begin
            if (done) begin
                nd++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 8) start = 1'b0;
            tick();
        end
        start = 1'b0;
        chk("b2b_done_count", 64'(nd), 64'd2);
        chk("b2b_first", 64'(first), 64'd6);
        chk("b2b_second", 64'(second), 64'd13);
        chk("b2b_y", {32'd0, y}, 64'h0000_0180);

        run_b({4{16'h0100}}, {12{16'h0040}}, {16'hFE00, 16'h0100, 16'h0000}, 1'b0, "cfg4x3");
        chk("cfg4x3_y", {16'd0, y2}, {16'd0, 16'hFF00, 16'h0200, 16'h0100});
        tick();
        chk("cfg4x3_done_pulse", {63'd0, done2}, 64'd0);

        for (int n = 0; n < 4; n++) begin
            xv2 = {rv(), rv(), rv(), rv()};
            for (int q = 0; q < 12; q++) wv2[q*16 +: 16] = rv();
            bv2 = {rv(), rv(), rv()};
            r   = 1'($urandom);
            run_b(xv2, wv2, bv2, r, $sformatf("rndb%0d", n));
            for (int i = 0; i < 4; i++) xs[i] = xv2[i*16 +: 16];
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 4; i++) ws[i] = wv2[(j*4+i)*16 +: 16];
                chk($sformatf("rndb%0d_y%0d", n, j), {48'd0, y2[j*16 +: 16]},
                    {48'd0, ref_out(4, xs, ws, bv2[j*16 +: 16], r)});
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
